// File: rtl/byte_lane_pkg.sv
// Shared types and defaults for the byte lane sequencer.
//   state_e       : sequencer FSM states (IDLE, SEND, FIN)
//   DATA_W_DEF    : default bits per lane
//   NUM_LANES_DEF : default lanes per frame
//   IDX_W_DEF     : lane index width derived from NUM_LANES_DEF
package byte_lane_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned NUM_LANES_DEF = 16;
  localparam int unsigned IDX_W_DEF     = $clog2(NUM_LANES_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage : byte_lane_pkg

// File: rtl/byte_lane_sequencer_if.sv
// Byte stream bus between the sequencer and the bit-timing encoder.
//   byte_out   : byte presented to the encoder
//   byte_valid : byte_out is valid
//   byte_ready : encoder accepts byte_out this cycle
//   lane_sel   : one-hot lane currently presented, zero when idle
// Modports: master (sequencer side), slave (encoder side).
interface byte_lane_sequencer_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_LANES = 16
);

  logic [DATA_W-1:0]    byte_out;
  logic                 byte_valid;
  logic                 byte_ready;
  logic [NUM_LANES-1:0] lane_sel;

  modport master (
    output byte_out,
    output byte_valid,
    output lane_sel,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    input  lane_sel,
    output byte_ready
  );

endinterface : byte_lane_sequencer_if

// File: rtl/byte_lane_mux.sv
// Combinational one-hot byte selector.
//   frame_i  : NUM_LANES lanes, lane k at [k*DATA_W +: DATA_W]
//   sel_i    : one-hot lane select
//   byte_o_c : selected lane; lane 0 when sel_i is not one-hot
module byte_lane_mux
  import byte_lane_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned NUM_LANES = NUM_LANES_DEF
) (
  input  logic [NUM_LANES*DATA_W-1:0] frame_i,
  input  logic [NUM_LANES-1:0]        sel_i,
  output logic [DATA_W-1:0]           byte_o_c
);

  // OR-reduce the selected lane; fall back to lane 0 for illegal selects.
  always_comb begin
    byte_o_c = frame_i[DATA_W-1:0];
    if ($onehot(sel_i)) begin
      byte_o_c = '0;
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        if (sel_i[k]) byte_o_c = byte_o_c | frame_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule : byte_lane_mux

// File: rtl/byte_lane_sequencer.sv
// Captures a frame of NUM_LANES bytes and streams it one byte per
// valid/ready handshake to the bit encoder.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : capture frame_in / len_m1 and begin streaming (IDLE only)
//   frame_in   : lane k at [k*DATA_W +: DATA_W]
//   len_m1     : bytes to send minus 1, clamped to NUM_LANES-1
//   bus        : byte_out / byte_valid / byte_ready / lane_sel (master)
//   busy       : capture cycle until final byte accepted
//   done       : one-cycle pulse after the final byte is accepted
// Build option: define BYTE_LANE_REVERSE_EN to stream from lane last
// down to lane 0 instead of ascending order.
module byte_lane_sequencer
  import byte_lane_pkg::*;
#(
  parameter  int unsigned DATA_W    = DATA_W_DEF,
  parameter  int unsigned NUM_LANES = NUM_LANES_DEF,
  localparam int unsigned IDX_W     = $clog2(NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NUM_LANES*DATA_W-1:0] frame_in,
  input  logic [IDX_W-1:0]            len_m1,
  byte_lane_sequencer_if.master       bus,
  output logic                        busy,
  output logic                        done
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_LANES - 1);

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [IDX_W-1:0]            last_q, last_d;
  logic [NUM_LANES*DATA_W-1:0] frame_q, frame_d;
  logic [DATA_W-1:0]           byte_out_q, byte_out_d;
  logic                        valid_q, valid_d;
  logic [NUM_LANES-1:0]        sel_q, sel_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [IDX_W-1:0]            len_clamp_c;
  logic [IDX_W-1:0]            first_idx_c;
  logic [IDX_W-1:0]            end_idx_c;
  logic [IDX_W-1:0]            step_idx_c;
  logic                        xfer_c;
  logic [DATA_W-1:0]           mux_byte_c;

  assign len_clamp_c = (32'(len_m1) > 32'(NUM_LANES - 1)) ? MAX_IDX : len_m1;
  assign xfer_c      = valid_q & bus.byte_ready;

  // Traversal direction: where a frame starts, where it ends, next index.
`ifdef BYTE_LANE_REVERSE_EN
  assign first_idx_c = len_clamp_c;
  assign end_idx_c   = '0;
  assign step_idx_c  = idx_q - IDX_W'(1);
`else
  assign first_idx_c = '0;
  assign end_idx_c   = last_q;
  assign step_idx_c  = idx_q + IDX_W'(1);
`endif

  // State, index and frame registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      frame_q    <= '0;
      byte_out_q <= '0;
      valid_q    <= 1'b0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      frame_q    <= frame_d;
      byte_out_q <= byte_out_d;
      valid_q    <= valid_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: capture in IDLE, advance on transfer, FIN lasts one cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    frame_d = frame_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          frame_d = frame_in;
          last_d  = len_clamp_c;
          idx_d   = first_idx_c;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer_c) begin
          if (idx_q == end_idx_c) state_d = FIN;
          else                    idx_d   = step_idx_c;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so they register in step with it.
  always_comb begin
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    sel_d      = '0;
    byte_out_d = '0;
    if (state_d == SEND) begin
      valid_d    = 1'b1;
      busy_d     = 1'b1;
      sel_d      = NUM_LANES'(1) << idx_d;
      byte_out_d = mux_byte_c;
    end
    if (state_d == FIN) done_d = 1'b1;
  end

  byte_lane_mux #(
    .DATA_W    (DATA_W),
    .NUM_LANES (NUM_LANES)
  ) u_mux (
    .frame_i  (frame_d),
    .sel_i    (sel_d),
    .byte_o_c (mux_byte_c)
  );

  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = valid_q;
  assign bus.lane_sel   = sel_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule : byte_lane_sequencer

// File: tb/tb_byte_lane_sequencer.sv
// Self-checking bench for byte_lane_sequencer: a 16-lane instance for the
// main sequences and a 12-lane instance for the length clamp.
module tb_byte_lane_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, start12;
  logic [127:0] frame_in;
  logic [95:0]  frame12;
  logic [3:0]   len_m1, len12;
  logic         busy, done, busy12, done12;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  byte_lane_sequencer_if #(.DATA_W(8), .NUM_LANES(16)) bus16 ();
  byte_lane_sequencer_if #(.DATA_W(8), .NUM_LANES(12)) bus12 ();

  byte_lane_sequencer #(.DATA_W(8), .NUM_LANES(16)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .frame_in (frame_in),
    .len_m1   (len_m1),
    .bus      (bus16),
    .busy     (busy),
    .done     (done)
  );

  byte_lane_sequencer #(.DATA_W(8), .NUM_LANES(12)) u_dut12 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start12),
    .frame_in (frame12),
    .len_m1   (len12),
    .bus      (bus12),
    .busy     (busy12),
    .done     (done12)
  );

  typedef struct {
    logic        ready;
    logic        v;
    logic [7:0]  b;
    logic [15:0] s;
    logic        bz;
    logic        dn;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic chk16(input string tag, input logic v, input logic [7:0] b,
                       input logic [15:0] s, input logic bz, input logic dn);
    check({tag, ".valid"}, 32'(bus16.byte_valid), 32'(v));
    check({tag, ".byte"},  32'(bus16.byte_out),   32'(b));
    check({tag, ".sel"},   32'(bus16.lane_sel),   32'(s));
    check({tag, ".busy"},  32'(busy),             32'(bz));
    check({tag, ".done"},  32'(done),             32'(dn));
  endtask

  // Lane presented by the t-th transfer of a frame whose last index is 'last'.
  function automatic int exp_lane(input int t, input int last);
`ifdef BYTE_LANE_REVERSE_EN
    return last - t;
`else
    return t;
`endif
  endfunction

  task automatic set_frame(input logic [7:0] base);
    for (int k = 0; k < 16; k++) frame_in[k*8 +: 8] = base + 8'(k);
  endtask

  task automatic pulse_start(input logic [7:0] base, input logic [3:0] len);
    set_frame(base);
    len_m1 = len;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  initial begin
    vec_t tbl[14];
    int   tr[10];
    int   lane, cnt;
    logic seen_done;

    // Reset with random inputs applied.
    rst_n    = 1'b0;
    start    = 1'($urandom);
    start12  = 1'($urandom);
    frame_in = {$urandom, $urandom, $urandom, $urandom};
    frame12  = {$urandom, $urandom, $urandom};
    len_m1   = 4'($urandom);
    len12    = 4'($urandom);
    bus16.byte_ready = 1'($urandom);
    bus12.byte_ready = 1'($urandom);
    repeat (3) @(negedge clk);
    chk16("reset", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    check("reset12.valid", 32'(bus12.byte_valid), 32'd0);
    check("reset12.sel",   32'(bus12.lane_sel),   32'd0);
    check("reset12.done",  32'(done12),           32'd0);
    start   = 1'b0;
    start12 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle.valid", 32'(bus16.byte_valid), 32'd0);
      check("idle.busy",  32'(busy),             32'd0);
      check("idle.sel",   32'(bus16.lane_sel),   32'd0);
    end

    // Full frame with ready held high.
    bus16.byte_ready = 1'b1;
    pulse_start(8'h10, 4'd15);
    for (int t = 0; t < 16; t++) begin
      lane = exp_lane(t, 15);
      chk16("full", 1'b1, 8'h10 + 8'(lane), 16'(1) << lane, 1'b1, 1'b0);
      @(negedge clk);
    end
    chk16("full_fin", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    chk16("full_idle", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);

    // Backpressure: ready pattern 1,0,0 repeating; table of expected outputs.
    tr = '{0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    for (int i = 0; i < 14; i++) begin
      tbl[i].ready = (i % 3 == 0);
      if (i < 10) begin
        lane      = exp_lane(tr[i], 3);
        tbl[i].v  = 1'b1;
        tbl[i].b  = 8'h10 + 8'(lane);
        tbl[i].s  = 16'(1) << lane;
        tbl[i].bz = 1'b1;
        tbl[i].dn = 1'b0;
      end else begin
        tbl[i].v  = 1'b0;
        tbl[i].b  = 8'h00;
        tbl[i].s  = 16'h0000;
        tbl[i].bz = 1'b0;
        tbl[i].dn = (i == 10);
      end
    end
    bus16.byte_ready = 1'b0;
    pulse_start(8'h10, 4'd3);
    for (int i = 0; i < 14; i++) begin
      chk16($sformatf("bp[%0d]", i), tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].bz, tbl[i].dn);
      bus16.byte_ready = tbl[i].ready;
      @(negedge clk);
    end

    // Start re-pulsed mid-stream and during FIN is ignored.
    bus16.byte_ready = 1'b1;
    pulse_start(8'h10, 4'd7);
    for (int t = 0; t < 8; t++) begin
      lane = exp_lane(t, 7);
      chk16("ign", 1'b1, 8'h10 + 8'(lane), 16'(1) << lane, 1'b1, 1'b0);
      if (t == 2) begin
        set_frame(8'hA0);
        len_m1 = 4'd2;
        start  = 1'b1;
      end
      if (t == 3) start = 1'b0;
      @(negedge clk);
    end
    chk16("ign_fin", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk16("ign_after_fin", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    chk16("ign_idle", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);

    // Single byte frame.
    pulse_start(8'h40, 4'd0);
    chk16("one", 1'b1, 8'h40, 16'h0001, 1'b1, 1'b0);
    @(negedge clk);
    chk16("one_fin", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);

    // Length clamp on a 12-lane instance.
    for (int k = 0; k < 12; k++) frame12[k*8 +: 8] = 8'h30 + 8'(k);
    len12            = 4'd15;
    bus12.byte_ready = 1'b1;
    start12          = 1'b1;
    @(negedge clk);
    start12   = 1'b0;
    cnt       = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (bus12.byte_valid) begin
        lane = exp_lane(cnt, 11);
        check("clamp.byte", 32'(bus12.byte_out), 32'(8'h30 + 8'(lane)));
        check("clamp.sel",  32'(bus12.lane_sel), 32'(12'(1) << lane));
        cnt++;
      end
      if (done12) seen_done = 1'b1;
      @(negedge clk);
    end
    check("clamp.count", 32'(cnt), 32'd12);
    check("clamp.done",  32'(seen_done), 32'd1);

    // Reset mid-frame after the 5th transfer.
    pulse_start(8'h10, 4'd15);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk16("midrst", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("midrst.done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk16("midrst_idle", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    pulse_start(8'h50, 4'd3);
    lane = exp_lane(0, 3);
    chk16("restart", 1'b1, 8'h50 + 8'(lane), 16'(1) << lane, 1'b1, 1'b0);
    seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("restart.done", 32'(seen_done), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_byte_lane_sequencer

// File: doc/byte_lane_sequencer.md
Name: byte_lane_sequencer

Overview:
- Parametrised successor to the fixed 16-lane one-hot byte selector.
- Captures a frame of NUM_LANES bytes and streams them one byte per handshake to the WS2812 bit encoder. Each byte is held while the encoder is busy.
- Sits between the pixel frame buffer and the bit-timing encoder.
- Adds a runtime frame length, a valid/ready handshake, a busy flag and a done pulse.

Parameters:
- DATA_W, 8, bits per lane (byte width).
- NUM_LANES, 16, lanes per frame; must be ≥2.
- IDX_W, $clog2(NUM_LANES), width of the lane index and length fields (localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to capture frame_in and begin streaming.
- frame_in  in  NUM_LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- len_m1  in  IDX_W  bytes to send minus 1; sampled with start.
- byte_out  out  DATA_W  current byte.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  encoder accepts byte_out this cycle.
- lane_sel  out  NUM_LANES  one-hot lane being presented; all-zero when idle.
- busy  out  1  high from the capture cycle until the final byte is accepted.
- done  out  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset values (asynchronous, rst_n=0): state=IDLE, byte_out=0, byte_valid=0, lane_sel=0, busy=0, done=0, frame register=0, index=0.
- States: IDLE, SEND, FIN.
- IDLE:
  - On start=1, register frame_in into the frame register, index=0, last=len_m1.
  - Next state SEND. busy rises on the next edge.
- SEND:
  - byte_valid=1. byte_out = frame register lane[index]. lane_sel = 1<<index.
  - Outputs are registered and driven from the state, index and frame registers, so they are stable while byte_valid=1 and byte_ready=0.
  - Transfer occurs when byte_valid & byte_ready on a rising edge.
  - Transfer with index<last: index += 1. The next byte is presented the following cycle with no bubble.
  - Transfer with index==last: go to FIN; byte_valid=0 and lane_sel=0 from the next cycle.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: start at cycle N gives first byte_valid at N+1. With byte_ready held high, the last transfer is at N+1+len_m1 and done is at N+2+len_m1.
- start is ignored while busy=1 or in FIN; the frame register is not overwritten.
- A len_m1 value ≥ NUM_LANES is clamped to NUM_LANES-1 at capture.
- len_m1=0 sends a single byte from lane 0.
- The index never wraps; it stops at last.
- byte_ready high outside SEND has no effect.
- Reset asserted mid-frame aborts immediately to the reset values, and no done pulse is issued. The first start after rst_n deasserts begins a fresh frame.

Optional Feature:
- Macro BYTE_LANE_REVERSE_EN.
- Defined: streaming order is reversed. The first byte is lane last and the index decrements to lane 0. lane_sel tracks the lane presented, and the clamp rules are unchanged.
- Undefined: ascending order as above. No reverse logic is synthesised.

Decomposition:
- Package byte_lane_pkg holds:
  - the state enum (IDLE, SEND, FIN) as a 2-bit typedef;
  - the DATA_W and NUM_LANES defaults;
  - a clog2-derived index-width helper constant.
- One sub-module: byte_lane_mux, a combinational one-hot selector parametrised by DATA_W and NUM_LANES.
  - Inputs: frame register and one-hot select.
  - Output: the selected byte; lane 0 when the select is not one-hot.
  - The sequencer instantiates it and registers its output as byte_out.

Test Plan:
- Reset values: hold rst_n=0 with random inputs → all outputs 0. Release, wait 5 cycles without start → byte_valid=0, busy=0, lane_sel=0.
- Full frame, ready high: frame lane k = 8'h10+k, len_m1=15, start at cycle 10 → byte_out 8'h10..8'h1F on cycles 11..26, lane_sel 16'h0001..16'h8000, done=1 only at cycle 27.
- Backpressure: len_m1=3, byte_ready toggles 1,0,0,1,… → each byte is held stable while ready=0, exactly 4 transfers in order 8'h10..8'h13, one done pulse.
- Start ignored while busy and length clamp:
  - start re-pulsed with a different frame mid-stream → the original bytes continue.
  - len_m1 above NUM_LANES-1 with non-default NUM_LANES=12, IDX_W=4 (len_m1=15) → 12 bytes sent.
- Reset mid-frame: rst_n low after the 5th transfer → outputs 0 the same cycle, no done. A new start streams from lane 0.
- BYTE_LANE_REVERSE_EN defined, len_m1=2 → byte_out 8'h12, 8'h11, 8'h10 with lane_sel 16'h0004, 16'h0002, 16'h0001, then done.
